// File: rtl/polar_to_cartesian_pipe.sv
// polar_to_cartesian_pipe: pipelined polar-to-Cartesian converter over a 15-degree quantised full circle.
// Four register levels (fold/LUT, multiply, round/sign, output) share one stall-wide advance enable.
module polar_to_cartesian_pipe #(
    parameter int R_WIDTH     = 8,
    parameter int THETA_WIDTH = 5,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [R_WIDTH-1:0]     in_r,
    input  logic [THETA_WIDTH-1:0] in_theta,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [R_WIDTH:0]       out_x,
    output logic [R_WIDTH:0]       out_y,
    output logic [TAG_WIDTH-1:0]   out_tag,
    output logic                   out_err
);
    localparam int PW = R_WIDTH + 9;
    localparam int OW = R_WIDTH + 1;

    function automatic logic [8:0] f_sin(input logic [2:0] i);
        case (i)
            3'd0:    f_sin = 9'd0;
            3'd1:    f_sin = 9'd66;
            3'd2:    f_sin = 9'd128;
            3'd3:    f_sin = 9'd181;
            3'd4:    f_sin = 9'd222;
            3'd5:    f_sin = 9'd247;
            3'd6:    f_sin = 9'd256;
            default: f_sin = 9'd0;
        endcase
    endfunction

    logic [31:0]          w_k;
    logic                 w_adv, w_err, w_sx, w_sy;
    logic [1:0]           w_q;
    logic [2:0]           w_m;
    logic [8:0]           w_ca, w_cb, w_cx, w_cy;
    logic [OW-1:0]        w_mx, w_my;

    logic                 r_s1_v, r_s1_err, r_s1_sx, r_s1_sy;
    logic [R_WIDTH-1:0]   r_s1_r;
    logic [TAG_WIDTH-1:0] r_s1_tag;
    logic [8:0]           r_s1_cx, r_s1_cy;
    logic                 r_s2_v, r_s2_err, r_s2_sx, r_s2_sy;
    logic [TAG_WIDTH-1:0] r_s2_tag;
    logic [PW-1:0]        r_s2_px, r_s2_py;
    logic                 r_s3_v, r_s3_err;
    logic [TAG_WIDTH-1:0] r_s3_tag;
    logic [OW-1:0]        r_s3_x, r_s3_y;
    logic                 r_o_v, r_o_err;
    logic [TAG_WIDTH-1:0] r_o_tag;
    logic [OW-1:0]        r_o_x, r_o_y;

    assign w_adv    = !r_o_v || out_ready;
    assign in_ready = w_adv;

    // Quadrant fold: odd quadrants swap the sin/cos table lookups.
    assign w_k   = 32'(in_theta);
    assign w_err = w_k > 32'd23;
    assign w_q   = w_k >= 32'd18 ? 2'd3 : w_k >= 32'd12 ? 2'd2 : w_k >= 32'd6 ? 2'd1 : 2'd0;
    assign w_m   = 3'(w_k - 32'd6 * 32'(w_q));
    assign w_ca  = f_sin(w_m);
    assign w_cb  = f_sin(3'd6 - w_m);
    assign w_cx  = w_err ? 9'd0 : (w_q[0] ? w_ca : w_cb);
    assign w_cy  = w_err ? 9'd0 : (w_q[0] ? w_cb : w_ca);
    assign w_sx  = !w_err && (w_q[0] ^ w_q[1]);
    assign w_sy  = !w_err && w_q[1];

    // Round half-up on the unsigned magnitude before negation keeps rounding symmetric.
    assign w_mx = OW'((r_s2_px + PW'(128)) >> 8);
    assign w_my = OW'((r_s2_py + PW'(128)) >> 8);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_v   <= 1'b0;
            r_s1_err <= 1'b0;
            r_s1_sx  <= 1'b0;
            r_s1_sy  <= 1'b0;
            r_s1_r   <= '0;
            r_s1_tag <= '0;
            r_s1_cx  <= '0;
            r_s1_cy  <= '0;
            r_s2_v   <= 1'b0;
            r_s2_err <= 1'b0;
            r_s2_sx  <= 1'b0;
            r_s2_sy  <= 1'b0;
            r_s2_tag <= '0;
            r_s2_px  <= '0;
            r_s2_py  <= '0;
            r_s3_v   <= 1'b0;
            r_s3_err <= 1'b0;
            r_s3_tag <= '0;
            r_s3_x   <= '0;
            r_s3_y   <= '0;
            r_o_v    <= 1'b0;
            r_o_err  <= 1'b0;
            r_o_tag  <= '0;
            r_o_x    <= '0;
            r_o_y    <= '0;
        end else if (w_adv) begin
            r_s1_v   <= in_valid;
            r_s1_err <= w_err;
            r_s1_sx  <= w_sx;
            r_s1_sy  <= w_sy;
            r_s1_r   <= in_r;
            r_s1_tag <= in_tag;
            r_s1_cx  <= w_cx;
            r_s1_cy  <= w_cy;
            r_s2_v   <= r_s1_v;
            r_s2_err <= r_s1_err;
            r_s2_sx  <= r_s1_sx;
            r_s2_sy  <= r_s1_sy;
            r_s2_tag <= r_s1_tag;
            r_s2_px  <= {9'd0, r_s1_r} * {R_WIDTH'(0), r_s1_cx};
            r_s2_py  <= {9'd0, r_s1_r} * {R_WIDTH'(0), r_s1_cy};
            r_s3_v   <= r_s2_v;
            r_s3_err <= r_s2_err;
            r_s3_tag <= r_s2_tag;
            r_s3_x   <= r_s2_sx ? -w_mx : w_mx;
            r_s3_y   <= r_s2_sy ? -w_my : w_my;
            r_o_v    <= r_s3_v;
            r_o_err  <= r_s3_err;
            r_o_tag  <= r_s3_tag;
            r_o_x    <= r_s3_x;
            r_o_y    <= r_s3_y;
        end
    end

    assign out_valid = r_o_v;
    assign out_err   = r_o_err;
    assign out_tag   = r_o_tag;
    assign out_x     = r_o_x;
    assign out_y     = r_o_y;
endmodule

// File: tb/tb_polar_to_cartesian_pipe.sv
// tb_polar_to_cartesian_pipe: directed + random stimulus against a sine-symmetry reference model.
module tb_polar_to_cartesian_pipe;
    logic       clock = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic       in_ready, out_valid, out_err;
    logic [7:0] in_r = '0;
    logic [4:0] in_theta = '0;
    logic [3:0] in_tag = '0, out_tag;
    logic [8:0] out_x, out_y;

    typedef struct {int x; int y; int tag; int err; int cyc;} exp_t;
    exp_t q[$];
    int tests = 0, fails = 0, cyc = 0;
    bit lat_chk = 0, held = 0;
    int hx, hy, htag, herr;
    int S[7] = '{0, 66, 128, 181, 222, 247, 256};

    polar_to_cartesian_pipe dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_theta(in_theta), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_tag(out_tag), .out_err(out_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Signed sine of k*15 degrees via half-circle symmetry; cosine is sine shifted by 90 degrees.
    function automatic int sinq(input int k);
        int a, mag;
        a = k % 12;
        mag = S[a <= 6 ? a : 12 - a];
        return k >= 12 ? -mag : mag;
    endfunction

    function automatic int scale(input int r, input int c);
        int m;
        m = (r * (c < 0 ? -c : c) + 128) / 256;
        return c < 0 ? -m : m;
    endfunction

    function automatic exp_t model(input int r, input int k, input int tag, input int c);
        exp_t e;
        e.tag = tag;
        e.cyc = c;
        e.err = k >= 24 ? 1 : 0;
        e.x = k >= 24 ? 0 : scale(r, sinq((k + 6) % 24));
        e.y = k >= 24 ? 0 : scale(r, sinq(k));
        return e;
    endfunction

    task automatic step(input bit v, input int r, input int th, input int tg, input bit ordy);
        exp_t e;
        in_valid = v; in_r = 8'(r); in_theta = 5'(th); in_tag = 4'(tg); out_ready = ordy;
        #1;
        chk("in_ready", int'(in_ready), int'(!out_valid || out_ready));
        if (held) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_x", int'($signed(out_x)), hx);
            chk("hold_y", int'($signed(out_y)), hy);
            chk("hold_tag", int'(out_tag), htag);
            chk("hold_err", int'(out_err), herr);
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("spurious_output", 1, 0);
            else begin
                e = q.pop_front();
                chk("x", int'($signed(out_x)), e.x);
                chk("y", int'($signed(out_y)), e.y);
                chk("tag", int'(out_tag), e.tag);
                chk("err", int'(out_err), e.err);
                if (lat_chk) chk("latency", cyc - e.cyc, 4);
            end
        end
        held = out_valid && !out_ready;
        hx = int'($signed(out_x)); hy = int'($signed(out_y));
        htag = int'(out_tag); herr = int'(out_err);
        if (v && in_ready) q.push_back(model(r, th, tg, cyc));
        @(negedge clock);
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) step(0, 0, 0, 0, 1);
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_x", int'(out_x), 0);
        chk("rst_y", int'(out_y), 0);
        chk("rst_tag", int'(out_tag), 0);
        chk("rst_err", int'(out_err), 0);
        reset_n = 1'b1;
        #1;
        chk("in_ready_after_rst", int'(in_ready), 1);
        lat_chk = 1;
        step(1, 200, 1, 1, 1);
        step(1, 200, 6, 2, 1);
        step(1, 200, 9, 3, 1);
        step(1, 200, 12, 4, 1);
        step(1, 200, 18, 5, 1);
        step(1, 255, 0, 6, 1);
        step(1, 0, 15, 7, 1);
        step(1, 100, 24, 'hA, 1);
        step(1, 77, 31, 'hB, 1);
        drain();
        lat_chk = 0;
        for (int i = 0; i < 12; i++) step(i < 5, 150 + i, i * 4, i, (i % 3) == 0);
        drain();
        for (int i = 0; i < 80; i++)
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
        drain();
        lat_chk = 1;
        for (int i = 0; i < 4; i++) step(1, 60 + i, i + 2, 12 + i, 1);
        chk("pre_rst_valid", int'(out_valid), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_x", int'(out_x), 0);
        chk("mid_rst_y", int'(out_y), 0);
        chk("mid_rst_tag", int'(out_tag), 0);
        chk("mid_rst_err", int'(out_err), 0);
        q.delete();
        held = 0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("in_ready_after_mid_rst", int'(in_ready), 1);
        step(1, 123, 3, 9, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
        chk("post_rst_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
